// File: rtl/ddr3_pattern_tester_if.sv
// -----------------------------------------------------------------------------
// ddr3_pattern_tester_if
//   User-side command/data port of the DDR3 memory-interface IP.
//
//   master : the traffic generator (drives commands and write data)
//   slave  : the memory-interface IP (or a model of it)
//
//   init_calib_complete  IP -> user  calibration finished
//   cmd_ready            IP -> user  command can be accepted
//   cmd / cmd_en / addr  user -> IP  command (3'b000 write, 3'b001 read)
//   wr_data_rdy          IP -> user  write data can be accepted
//   wr_data*             user -> IP  write data, strobe, last beat, byte mask
//   rd_data*             IP -> user  read data, strobe, last beat
//   sr_req / ref_req     user -> IP  self-refresh / refresh requests
// -----------------------------------------------------------------------------
interface ddr3_pattern_tester_if;
  logic         init_calib_complete;
  logic         cmd_ready;
  logic [2:0]   cmd;
  logic         cmd_en;
  logic [27:0]  addr;
  logic         wr_data_rdy;
  logic [127:0] wr_data;
  logic         wr_data_en;
  logic         wr_data_end;
  logic [7:0]   wr_data_mask;
  logic [127:0] rd_data;
  logic         rd_data_valid;
  logic         rd_data_end;
  logic         sr_req;
  logic         ref_req;

  modport master (
    input  init_calib_complete, cmd_ready, wr_data_rdy,
           rd_data, rd_data_valid, rd_data_end,
    output cmd, cmd_en, addr, wr_data, wr_data_en, wr_data_end,
           wr_data_mask, sr_req, ref_req
  );

  modport slave (
    output init_calib_complete, cmd_ready, wr_data_rdy,
           rd_data, rd_data_valid, rd_data_end,
    input  cmd, cmd_en, addr, wr_data, wr_data_en, wr_data_end,
           wr_data_mask, sr_req, ref_req
  );
endinterface

// File: rtl/ddr3_pattern_tester.sv
// -----------------------------------------------------------------------------
// ddr3_pattern_tester
//   Memory traffic generator / checker for the DDR3 IP user port. After a start
//   pulse and calibration it writes a deterministic 128-bit pattern to
//   2^LINE_W lines, reads every line back one at a time, and reports the result.
//
//   Pattern for line i, 32-bit word k (word 0 = bits 31:0): SEED + 4*i + k.
//   Line address: BASE_ADDR + i*ADDR_STEP (28 bits).
//
// Ports
//   clk, reset        IP user clock, synchronous active-high reset
//   start             one-cycle start pulse (ignored while busy)
//   bus               IP command/data port (master side)
//   busy              test in progress
//   done              test finished (held until the next start)
//   pass              done with no errors
//   error_count       mismatches plus read timeouts, saturating at 16'hFFFF
//   first_error_addr  line address of the first error
// -----------------------------------------------------------------------------
module ddr3_pattern_tester #(
  parameter int unsigned LINE_W     = 10,
  parameter int unsigned ADDR_STEP  = 8,
  parameter logic [27:0] BASE_ADDR  = 28'h0000000,
  parameter logic [31:0] SEED       = 32'h1234_5678,
  parameter int unsigned RD_TIMEOUT = 1023
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  ddr3_pattern_tester_if.master        bus,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [15:0]                  error_count,
  output logic [27:0]                  first_error_addr
);

  localparam int unsigned        TMO_W     = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);
  localparam logic [LINE_W-1:0]  LAST_IDX  = '1;
  localparam logic [TMO_W-1:0]   TMO_LIMIT = TMO_W'(RD_TIMEOUT);
  localparam logic [2:0]         CMD_WR    = 3'b000;
  localparam logic [2:0]         CMD_RD    = 3'b001;
  localparam logic [15:0]        ERR_MAX   = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CAL,
    S_WR,
    S_RD_CMD,
    S_RD_WAIT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [LINE_W-1:0]  idx_q,   idx_d;
  logic [TMO_W-1:0]   tmo_q,   tmo_d;
  logic [15:0]        err_q,   err_d;
  logic [27:0]        ferr_q,  ferr_d;

  logic [27:0]        line_addr;
  logic [31:0]        pat_base;
  logic [127:0]       line_pattern;
  logic               wr_fire;
  logic               line_error;

  // Address and expected data depend only on the registered index, so they
  // stay stable across any ready stall.
  assign line_addr    = BASE_ADDR + 28'(idx_q) * 28'(ADDR_STEP);
  assign pat_base     = SEED + (32'(idx_q) << 2);
  assign line_pattern = {pat_base + 32'd3, pat_base + 32'd2, pat_base + 32'd1, pat_base};

  // A write line needs the command and its data accepted in the same cycle.
  assign wr_fire = bus.cmd_ready & bus.wr_data_rdy;

  // Single-beat reads: the last-beat flag carries no extra information.
  logic unused_rd_data_end;
  assign unused_rd_data_end = bus.rd_data_end;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: reset is sampled on the clock edge (synchronous), and every flop uses
  // non-blocking assignment so all registers update together from the values
  // computed before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    ferr_d     = ferr_q;
    line_error = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          idx_d   = '0;
          err_d   = '0;
          ferr_d  = '0;
          state_d = S_WAIT_CAL;
        end
      end

      S_WAIT_CAL: begin
        if (bus.init_calib_complete) state_d = S_WR;
      end

      S_WR: begin
        if (wr_fire) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_RD_CMD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_RD_CMD: begin
        if (bus.cmd_ready) begin
          tmo_d   = '0;
          state_d = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        // Valid data wins over a timeout expiring in the same cycle.
        if (bus.rd_data_valid || (tmo_q == TMO_LIMIT)) begin
          line_error = bus.rd_data_valid ? (bus.rd_data != line_pattern) : 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_RD_CMD;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (line_error) begin
      if (err_q != ERR_MAX) err_d = err_q + 16'd1;
      // Only the 0 -> 1 transition records the address.
      if (err_q == 16'd0)   ferr_d = line_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.cmd         = CMD_WR;
    bus.cmd_en      = 1'b0;
    bus.addr        = '0;
    bus.wr_data     = '0;
    bus.wr_data_en  = 1'b0;
    bus.wr_data_end = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
    pass            = 1'b0;

    unique case (state_q)
      S_IDLE: busy = 1'b0;

      S_WR: begin
        bus.addr        = line_addr;
        bus.wr_data     = line_pattern;
        bus.cmd_en      = wr_fire;
        bus.wr_data_en  = wr_fire;
        bus.wr_data_end = wr_fire;
      end

      S_RD_CMD: begin
        bus.cmd    = CMD_RD;
        bus.addr   = line_addr;
        bus.cmd_en = bus.cmd_ready;
      end

      S_RD_WAIT: begin
        bus.cmd  = CMD_RD;
        bus.addr = line_addr;
      end

      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        pass = (err_q == 16'd0);
      end

      default: ;
    endcase
  end

  assign bus.wr_data_mask = 8'h00;
  assign bus.sr_req       = 1'b0;
  assign bus.ref_req      = 1'b0;  // the IP refreshes on its own

  assign error_count      = err_q;
  assign first_error_addr = ferr_q;

endmodule

// File: tb/tb_ddr3_pattern_tester.sv
// -----------------------------------------------------------------------------
// tb_ddr3_pattern_tester
//   Drives ddr3_pattern_tester against a small DDR3 IP model (memory array,
//   fixed read latency, optional bit flip / dropped read response) and checks
//   writes through an expected-transaction queue plus final status per run.
// -----------------------------------------------------------------------------
module tb_ddr3_pattern_tester;

  localparam int          LINE_W     = 4;
  localparam int          NLINES     = 16;
  localparam int          RD_TIMEOUT = 31;
  localparam int          RD_LAT     = 20;
  localparam logic [31:0] SEED       = 32'h1234_5678;
  localparam int          RUN_BUDGET = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] error_count;
  logic [27:0] first_error_addr;

  ddr3_pattern_tester_if bus ();

  ddr3_pattern_tester #(
    .LINE_W     (LINE_W),
    .ADDR_STEP  (8),
    .BASE_ADDR  (28'h0000000),
    .SEED       (SEED),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .bus              (bus.master),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .error_count      (error_count),
    .first_error_addr (first_error_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------------------------------------------------------------------
  // IP model and write monitor
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [27:0]  addr;
    logic [127:0] data;
    int           cyc;
  } wr_txn_t;

  wr_txn_t      exp_q[$];
  wr_txn_t      obs_q[$];
  logic [127:0] mem [NLINES];
  int           rd_cmd_cyc [NLINES];
  int           flip_line = -1;
  int           drop_line = -1;
  int           cyc = 0;
  logic         rd_pending;
  int           rd_timer;
  int           rd_line;

  always @(posedge clk) begin
    cyc               <= cyc + 1;
    bus.rd_data_valid <= 1'b0;
    bus.rd_data_end   <= 1'b0;
    if (reset) begin
      rd_pending  <= 1'b0;
      rd_timer    <= 0;
      rd_line     <= 0;
      bus.rd_data <= '0;
    end else begin
      if (bus.cmd_en && bus.cmd_ready && bus.cmd == 3'b000 &&
          bus.wr_data_en && bus.wr_data_rdy) begin
        mem[bus.addr[6:3]] <= bus.wr_data;
        obs_q.push_back('{bus.addr, bus.wr_data, cyc});
      end
      if (bus.cmd_en && bus.cmd_ready && bus.cmd == 3'b001) begin
        rd_cmd_cyc[bus.addr[6:3]] <= cyc;
        if (int'(bus.addr[6:3]) != drop_line) begin
          rd_pending <= 1'b1;
          rd_timer   <= RD_LAT;
          rd_line    <= int'(bus.addr[6:3]);
        end
      end
      if (rd_pending) begin
        if (rd_timer == 1) begin
          rd_pending        <= 1'b0;
          bus.rd_data_valid <= 1'b1;
          bus.rd_data_end   <= 1'b1;
          bus.rd_data       <= mem[rd_line] ^ ((rd_line == flip_line) ? 128'd1 : 128'd0);
        end else begin
          rd_timer <= rd_timer - 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Expected values
  // ---------------------------------------------------------------------------
  function automatic logic [127:0] exp_line(input int i);
    logic [31:0] b;
    b = SEED + 32'(4 * i);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic push_expected();
    for (int i = 0; i < NLINES; i++) exp_q.push_back('{28'(i * 8), exp_line(i), 0});
  endtask

  // ---------------------------------------------------------------------------
  // Sequencing helpers
  // ---------------------------------------------------------------------------
  task automatic start_run();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < RUN_BUDGET) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", name, done, n);
    end
  endtask

  // Pops the expected write queue against the observed writes in order.
  task automatic sb_compare_writes(input string name);
    wr_txn_t e, o;
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_errors++;
      $display("FAIL %s_write_count: got %0d writes, required %0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o.addr !== e.addr || o.data !== e.data) begin
        n_errors++;
        $display("FAIL %s_write: got addr=%0d data=%h, required addr=%0d data=%h",
                 name, o.addr, o.data, e.addr, e.data);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset                   = 1'b1;
    start                   = 1'b0;
    bus.init_calib_complete = 1'b1;
    bus.cmd_ready           = 1'b1;
    bus.wr_data_rdy         = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.cmd, bus.cmd_en, bus.addr, bus.wr_data, bus.wr_data_en, bus.wr_data_end,
         bus.wr_data_mask, bus.sr_req, bus.ref_req} !== '0) begin
      n_errors++;
      $display("FAIL reset_bus: cmd=%b cmd_en=%b addr=%h wr_data=%h wr_en=%b wr_end=%b mask=%h sr=%b ref=%b, required all 0",
               bus.cmd, bus.cmd_en, bus.addr, bus.wr_data, bus.wr_data_en, bus.wr_data_end,
               bus.wr_data_mask, bus.sr_req, bus.ref_req);
    end
    n_checks++;
    if ({busy, done, pass, error_count, first_error_addr} !== '0) begin
      n_errors++;
      $display("FAIL reset_status: busy=%b done=%b pass=%b err=%0d ferr=%h, required all 0",
               busy, done, pass, error_count, first_error_addr);
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_ideal();
    logic consecutive;
    push_expected();
    start_run();
    wait_done("ideal");
    consecutive = (obs_q.size() == NLINES);
    for (int i = 1; i < obs_q.size(); i++)
      if (obs_q[i].cyc != obs_q[0].cyc + i) consecutive = 1'b0;
    n_checks++;
    if (consecutive !== 1'b1) begin
      n_errors++;
      $display("FAIL ideal_consecutive: got %0d writes not back-to-back, required %0d consecutive strobes",
               obs_q.size(), NLINES);
    end
    n_checks++;
    if (obs_q.size() < 2 || obs_q[1].data[31:0] !== 32'h1234_567C) begin
      n_errors++;
      $display("FAIL ideal_line1_word0: got %h, required 1234567c",
               (obs_q.size() < 2) ? 32'hx : obs_q[1].data[31:0]);
    end
    n_checks++;
    if ({done, pass, busy, error_count} !== {1'b1, 1'b1, 1'b0, 16'd0}) begin
      n_errors++;
      $display("FAIL ideal_status: got done=%b pass=%b busy=%b err=%0d, required 1 1 0 0",
               done, pass, busy, error_count);
    end
    sb_compare_writes("ideal");
  endtask

  task automatic test_bit_flip();
    flip_line = 5;
    push_expected();
    start_run();
    wait_done("flip");
    n_checks++;
    if ({done, pass, error_count, first_error_addr} !== {1'b1, 1'b0, 16'd1, 28'd40}) begin
      n_errors++;
      $display("FAIL flip_status: got done=%b pass=%b err=%0d ferr=%0d, required 1 0 1 40",
               done, pass, error_count, first_error_addr);
    end
    flip_line = -1;
    sb_compare_writes("flip");
  endtask

  task automatic test_stall();
    int  n;
    logic found;
    push_expected();
    start_run();
    n = 0;
    found = 1'b0;
    while (!found && n < 200) begin
      if (busy === 1'b1 && bus.cmd === 3'b000 && bus.addr === 28'd24) found = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL stall_reach_idx3: got no WR at addr 24 within %0d cycles, required one", n);
    end else begin
      bus.cmd_ready = 1'b0;
      for (int k = 0; k < 7; k++) begin
        #1;
        n_checks++;
        if ({bus.cmd_en, bus.wr_data_en, bus.wr_data_end, bus.cmd, bus.addr} !== {3'b000, 3'b000, 28'd24} ||
            bus.wr_data !== exp_line(3)) begin
          n_errors++;
          $display("FAIL stall_stable: cycle %0d got cmd_en=%b wr_en=%b wr_end=%b cmd=%b addr=%0d data=%h, required 0 0 0 000 24 %h",
                   k, bus.cmd_en, bus.wr_data_en, bus.wr_data_end, bus.cmd, bus.addr, bus.wr_data, exp_line(3));
        end
        // A start pulse while busy must not restart the run.
        if (k == 2) start = 1'b1;
        if (k == 3) start = 1'b0;
        @(negedge clk);
      end
      start         = 1'b0;
      bus.cmd_ready = 1'b1;
    end
    wait_done("stall");
    n_checks++;
    if ({pass, error_count} !== {1'b1, 16'd0}) begin
      n_errors++;
      $display("FAIL stall_status: got pass=%b err=%0d, required 1 0", pass, error_count);
    end
    sb_compare_writes("stall");
  endtask

  task automatic test_timeout();
    int n;
    int elapsed;
    drop_line = 2;
    push_expected();
    start_run();
    n = 0;
    while (error_count === 16'd0 && n < RUN_BUDGET) begin
      @(negedge clk);
      n++;
    end
    elapsed = cyc - rd_cmd_cyc[2] - 1;
    n_checks++;
    if (error_count === 16'd0 || elapsed < RD_TIMEOUT || elapsed > RD_TIMEOUT + 1) begin
      n_errors++;
      $display("FAIL timeout_latency: got err=%0d after %0d cycles, required 1 after %0d..%0d cycles",
               error_count, elapsed, RD_TIMEOUT, RD_TIMEOUT + 1);
    end
    wait_done("timeout");
    n_checks++;
    if ({done, pass, error_count, first_error_addr} !== {1'b1, 1'b0, 16'd1, 28'd16}) begin
      n_errors++;
      $display("FAIL timeout_status: got done=%b pass=%b err=%0d ferr=%0d, required 1 0 1 16",
               done, pass, error_count, first_error_addr);
    end
    drop_line = -1;
    sb_compare_writes("timeout");
  endtask

  task automatic test_cal_wait();
    int bad;
    @(negedge clk) bus.init_calib_complete = 1'b0;
    push_expected();
    start_run();
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      if (busy !== 1'b1 || bus.cmd_en !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 0 || obs_q.size() !== 0) begin
      n_errors++;
      $display("FAIL cal_wait_idle: got %0d bad cycles and %0d writes, required 0 and 0", bad, obs_q.size());
    end
    bus.init_calib_complete = 1'b1;
    wait_done("cal_wait");
    n_checks++;
    if ({pass, error_count} !== {1'b1, 16'd0}) begin
      n_errors++;
      $display("FAIL cal_wait_status: got pass=%b err=%0d, required 1 0", pass, error_count);
    end
    sb_compare_writes("cal_wait");
  endtask

  task automatic test_reset_mid();
    int  n;
    logic found;
    start_run();
    n = 0;
    found = 1'b0;
    while (!found && n < 200) begin
      if (busy === 1'b1 && bus.cmd === 3'b000 && bus.addr === 28'd40) found = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (!found || {bus.cmd, bus.cmd_en, bus.addr, bus.wr_data, bus.wr_data_en, bus.wr_data_end} !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_bus: found=%b cmd=%b cmd_en=%b addr=%h wr_data=%h wr_en=%b wr_end=%b, required found and all 0",
               found, bus.cmd, bus.cmd_en, bus.addr, bus.wr_data, bus.wr_data_en, bus.wr_data_end);
    end
    n_checks++;
    if ({busy, done, pass, error_count, first_error_addr} !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_status: busy=%b done=%b pass=%b err=%0d ferr=%h, required all 0",
               busy, done, pass, error_count, first_error_addr);
    end
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
    push_expected();
    start_run();
    wait_done("reset_mid");
    n_checks++;
    if ({done, pass, error_count} !== {1'b1, 1'b1, 16'd0}) begin
      n_errors++;
      $display("FAIL reset_mid_rerun: got done=%b pass=%b err=%0d, required 1 1 0", done, pass, error_count);
    end
    sb_compare_writes("reset_mid");
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_bit_flip();
    test_stall();
    test_timeout();
    test_cal_wait();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ddr3_pattern_tester.md
Name: ddr3_pattern_tester

Overview:
- User-side traffic generator and checker that drives the DDR3 memory-interface IP command/data port on the Tang Primer 20K board.
- After calibration completes and a start pulse arrives, it writes a deterministic 128-bit pattern to a block of lines.
- It then reads every line back and compares it against the pattern.
- It reports busy/done/pass, an error count and the first failing address, which the top level shows on the LEDs.

Parameters:
- LINE_W, 10, number of lines tested = 2^LINE_W
- ADDR_STEP, 8, address increment per line (16-bit words per BL8 burst)
- BASE_ADDR, 28'h0000000, address of line 0
- SEED, 32'h1234_5678, pattern seed
- RD_TIMEOUT, 1023, cycles to wait for rd_data_valid before declaring an error

Ports:
- clk  in  1  IP user clock (clk_out of memory interface)
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle start pulse
- init_calib_complete  in  1  IP calibration done
- cmd_ready  in  1  IP accepts command
- cmd  out  3  3'b000 write, 3'b001 read
- cmd_en  out  1  command strobe
- addr  out  28  command address
- wr_data_rdy  in  1  IP accepts write data
- wr_data  out  128  write data
- wr_data_en  out  1  write data strobe
- wr_data_end  out  1  last write beat (equals wr_data_en)
- wr_data_mask  out  8  constant 8'h00
- rd_data  in  128  read data
- rd_data_valid  in  1  read data strobe
- rd_data_end  in  1  last read beat (ignored; single beat per command)
- sr_req  out  1  constant 0
- ref_req  out  1  constant 0 (IP auto-refresh)
- busy  out  1  test in progress
- done  out  1  test finished, held
- pass  out  1  done with error_count==0
- error_count  out  16  mismatches plus timeouts, saturating
- first_error_addr  out  28  address of first error

Behaviour:
- Pattern for line i, word k (k=0..3, word 0 = bits 31:0): P(i,k) = SEED + 4*i + k, mod 2^32.
- Line address: BASE_ADDR + i*ADDR_STEP, truncated to 28 bits.
- Reset values: state IDLE; cmd=0, cmd_en=0, addr=0, wr_data=0, wr_data_en=0, wr_data_end=0; busy=0, done=0, pass=0, error_count=0, first_error_addr=0.
- Reset is valid in any state, including mid-operation: the block returns to IDLE on the next edge and all outputs take their reset values.

States:
- IDLE: on start=1, clear error_count, first_error_addr, done, pass and the line index; go to WAIT_CAL. busy=1 in every state except IDLE and DONE.
- WAIT_CAL: remain until init_calib_complete=1, then go to WR.
- WR:
  - cmd_en = wr_data_en = wr_data_end = cmd_ready & wr_data_rdy (combinational from registered state, index and pattern).
  - cmd=000 and addr/wr_data for the current index are driven throughout the state.
  - Each strobe cycle advances the index. After index 2^LINE_W-1 is strobed, clear the index and go to RD_CMD.
  - A stall on either ready holds all outputs stable, with no strobe.
- RD_CMD: cmd=001, cmd_en = cmd_ready. On the strobe, load the timeout counter with 0 and go to RD_WAIT.
- RD_WAIT:
  - On rd_data_valid, compare all 128 bits against P(index,0..3).
  - If the counter reaches RD_TIMEOUT without valid, count one error.
  - In either case, latch first_error_addr on the first error.
  - Then advance the index: go back to RD_CMD, or go to DONE after the last line.
  - A valid and a timeout arriving in the same cycle: the valid takes priority.
- DONE: done=1, pass=(error_count==0), busy=0. A new start behaves as in IDLE.

Further rules:
- start is ignored while busy.
- rd_data_valid outside RD_WAIT is ignored and not counted.
- error_count saturates at 16'hFFFF.
- first_error_addr is written only when error_count transitions from 0 to 1.
- At most one outstanding read at a time.

Test Plan:
- Ideal IP model (ready always 1, read latency 20 cycles, correct memory), LINE_W=4, start → 16 consecutive write strobes with addr 0,8,…,120 and line 1 word 0 = 32'h1234_567C; then done=1, pass=1, error_count=0.
- Memory model flips bit 0 of line 5 → error_count=1, first_error_addr=28'd40, pass=0.
- cmd_ready low for 7 cycles during WR at index 3 → no strobe and outputs stable during the stall; index 3 is written exactly once; final pass=1.
- Model drops the read response for line 2, RD_TIMEOUT=31 → error after 31 cycles, first_error_addr=16, test completes with error_count=1.
- init_calib_complete held low for 100 cycles after start → busy=1 and no cmd_en until it rises.
- Reset asserted mid-WR, then start reissued → outputs at reset values the cycle after reset; the second run passes cleanly.
